// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the instruction memory, the hazard unit and decode.
// The master modport is the fetch stage itself; the slave modport is its surroundings.
interface fetch_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_req_o, imem_addr_o,
        output if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o,
        input  if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-cycle-latency imem, skid buffer for stalls,
// redirect from EX and IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    localparam slot_t       BUBBLE     = '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        inflight_reg;
    logic [31:0] inflight_pc_reg;
    slot_t       skid_reg;
    slot_t       ifid_reg;

    logic        issue;
    logic [31:0] redirect_target;
    slot_t       resp;

    // A request goes out only when nothing holds the front end back this cycle.
    assign issue = !bus.redirect_i && !bus.stall_i &&
                   ((state_reg == FETCH) || (state_reg == HOLD));

    assign redirect_target = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign resp            = '{valid: 1'b1, pc: inflight_pc_reg, instr: bus.imem_rdata_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_ADDR;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'd0;
            skid_reg        <= BUBBLE;
            ifid_reg        <= BUBBLE;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg          <= pc_reg + 32'd4;
                inflight_pc_reg <= pc_reg;
            end

            if (bus.redirect_i) begin
                // The response of the last request (if any) is dropped here: it is never
                // written into skid or IF/ID, and the in-flight flag clears via issue=0.
                pc_reg    <= redirect_target;
                skid_reg  <= BUBBLE;
                ifid_reg  <= BUBBLE;
                state_reg <= FETCH;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        state_reg <= FETCH;
                    end
                    FETCH: begin
                        if (bus.stall_i) begin
                            if (inflight_reg) begin
                                skid_reg  <= resp;
                                state_reg <= HOLD;
                            end
                            if (bus.flush_i) begin
                                ifid_reg <= BUBBLE;
                            end
                        end else begin
                            ifid_reg <= (bus.flush_i || !inflight_reg) ? BUBBLE : resp;
                        end
                    end
                    HOLD: begin
                        if (bus.stall_i) begin
                            if (bus.flush_i) begin
                                ifid_reg <= BUBBLE;
                            end
                        end else begin
                            // Skid drains into IF/ID while the next request goes out.
                            ifid_reg  <= bus.flush_i ? BUBBLE : skid_reg;
                            skid_reg  <= BUBBLE;
                            state_reg <= FETCH;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = pc_reg;
    assign bus.if_id_valid_o = ifid_reg.valid;
    assign bus.if_id_pc_o    = ifid_reg.pc;
    assign bus.if_id_pc4_o   = ifid_reg.pc + 32'd4;
    assign bus.if_id_instr_o = ifid_reg.instr;
endmodule
